sseg_p2s_tx: RTL and testbench
==============================

Name: sseg_p2s_tx

Overview:
Parallel-to-serial transmitter for the board's serial seven-segment display chain (cascaded 8-bit shift/latch registers). Accepts one 64-bit segment frame, already in display bit order from the segment-map stage, and shifts it out MSB first on a divided shift clock. After the last bit it pulses the output-latch enable so the display updates atomically. Sits between the segment-map stage and the board pins.

Parameters:
DATA_BITS, 64, frame length in bits; the counter width is derived from it.
CLK_DIV, 2, half-period of s_clk in clk cycles; legal values are 1 or more.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  frame request; sampled only when busy=0
par_data  input  DATA_BITS  segment frame; captured on the accepting edge
busy  output  1  frame in progress
done  output  1  one-cycle pulse after frame latched
s_clk  output  1  serial shift clock to the display chain
s_out  output  1  serial data, MSB first
s_pen  output  1  output-latch enable pulse, active-high
s_clrn  output  1  display shift-register clear, active-low

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values: busy=0, done=0, s_clk=0, s_out=0, s_pen=0, s_clrn=0. s_clrn rises to 1 on the first edge with rst=0 and stays 1.
- Reset mid-frame: abort immediately on the reset edge with the values above. No latch pulse is issued and no done pulse is issued. The display keeps its previous frame.
- States:
  - IDLE: busy=0, s_clk=0, s_out=0, s_pen=0.
  - SHIFT: 2*CLK_DIV cycles per bit.
  - LATCH: CLK_DIV cycles.
  - DONE: 1 cycle.
- IDLE to SHIFT: taken when start=1 at edge E.
  - On edge E: par_data is loaded into the shift register, bit_cnt=0, div_cnt=0, busy=1.
  - s_out=par_data[DATA_BITS-1] from cycle E+1.
- SHIFT, per bit:
  - s_clk=0 for CLK_DIV cycles, then s_clk=1 for CLK_DIV cycles. The chain captures on the rising edge of s_clk.
  - At the end of the high phase, s_clk returns to 0 and the next bit appears on s_out in the same cycle.
  - s_out is stable for the full 2*CLK_DIV bit period.
  - Bit order: par_data[DATA_BITS-1] first, par_data[0] last.
- SHIFT to LATCH: taken after the high phase of bit DATA_BITS-1.
  - In LATCH: s_clk=0, s_out=0, s_pen=1 for CLK_DIV cycles.
- LATCH to DONE: in DONE, s_pen=0, busy=0, done=1 for exactly one cycle. Next state is IDLE.
- Start acceptance:
  - start is accepted whenever busy=0, including the DONE cycle. If start=1 in the DONE cycle, the next frame begins with no idle gap.
  - start=1 while busy=1 is ignored and not queued.
  - par_data changes while busy=1 have no effect.
- Latency: start accepted at edge E gives:
  - busy=1 for cycles E+1 .. E+(2*DATA_BITS+1)*CLK_DIV.
  - done=1 in cycle E+(2*DATA_BITS+1)*CLK_DIV+1.
  - With defaults: busy for 258 cycles, done at E+259.
- Counters: div_cnt wraps at CLK_DIV-1. bit_cnt counts 0..DATA_BITS-1 and must not wrap into a 65th bit.
- No s_clk edges occur outside SHIFT.

Test Plan:
- Defaults, par_data=64'h8000_0000_0000_0001, start for 1 cycle -> s_out=1 in cycles 1-4 and 253-256, 0 elsewhere; exactly 64 s_clk rising edges; s_pen=1 in cycles 257-258; done=1 in cycle 259 only; a bench 64-bit shift model latches 64'h8000_0000_0000_0001.
- par_data=64'hAAAA_AAAA_AAAA_AAAA, then 64'hFFFF_FFFF_FFFF_FFFF issued back-to-back with start held in the DONE cycle -> both frames captured exactly; busy low for only the DONE cycle; two s_pen pulses.
- start pulsed at cycle 50 of a frame with different par_data -> ignored; captured frame equals the original data; only one done pulse.
- rst asserted at cycle 100 of a frame -> next cycle: all outputs 0, including s_clrn; no s_pen pulse; s_clrn=1 one cycle after rst falls; a new start then works normally.
- CLK_DIV=1, par_data=64'h0123_4567_89AB_CDEF -> s_clk toggles every cycle; busy for 129 cycles; done at E+130; captured value correct.
- Reset with start held high -> no frame begins until rst=0; the first accepted frame starts on the first edge with rst=0.

Source files
------------

// File: rtl/sseg_p2s_tx.sv
// Serial seven-segment transmitter: shifts a parallel frame out MSB first on a
// divided shift clock, then pulses the output-latch enable so the display updates atomically.
module sseg_p2s_tx #(
  parameter int DATA_BITS = 64,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] par_data,
  output logic                 busy,
  output logic                 done,
  output logic                 s_clk,
  output logic                 s_out,
  output logic                 s_pen,
  output logic                 s_clrn
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t               state, state_n;
  logic [DW-1:0]        div_cnt, div_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 s_clk_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_out   <= 1'b0;
      s_pen   <= 1'b0;
      s_clrn  <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      // Outputs are registered from next-state values so they line up with the state.
      busy    <= (state_n == SHIFT) || (state_n == LATCH);
      done    <= (state_n == DONE);
      s_clk   <= s_clk_n;
      s_out   <= (state_n == SHIFT) ? sh_n[DATA_BITS-1] : 1'b0;
      s_pen   <= (state_n == LATCH);
      s_clrn  <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    s_clk_n   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = SHIFT;
          sh_n      = par_data;
          bit_cnt_n = '0;
          div_cnt_n = '0;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        s_clk_n = s_clk;
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (!s_clk) begin
            s_clk_n = 1'b1;
          end else begin
            s_clk_n = 1'b0;
            // Last bit ends here; the counter never advances past DATA_BITS-1.
            if (bit_cnt == BIT_LAST) begin
              state_n = LATCH;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
              sh_n      = {sh[DATA_BITS-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          state_n   = DONE;
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sseg_p2s_tx.sv
// Directed bench for sseg_p2s_tx: default divider instance plus a CLK_DIV=1 instance,
// each observed by a 64-bit shift/latch model of the display chain.
module tb_sseg_p2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [63:0] par_a = '0, par_b = '0;
  logic busy_a, done_a, s_clk_a, s_out_a, s_pen_a, s_clrn_a;
  logic busy_b, done_b, s_clk_b, s_out_b, s_pen_b, s_clrn_b;

  sseg_p2s_tx dut_a (
    .clk(clk), .rst(rst), .start(start_a), .par_data(par_a),
    .busy(busy_a), .done(done_a), .s_clk(s_clk_a), .s_out(s_out_a),
    .s_pen(s_pen_a), .s_clrn(s_clrn_a)
  );

  sseg_p2s_tx #(.DATA_BITS(64), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .par_data(par_b),
    .busy(busy_b), .done(done_b), .s_clk(s_clk_b), .s_out(s_out_b),
    .s_pen(s_pen_b), .s_clrn(s_clrn_b)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Display-chain models, updated just after each active edge.
  logic [63:0] model_a = '0, latched_a = '0, model_b = '0, latched_b = '0;
  int rises_a = 0, pens_a = 0, dones_a = 0, viol_a = 0;
  int rises_b = 0, pens_b = 0, dones_b = 0, viol_b = 0;
  logic pclk_a = 1'b0, ppen_a = 1'b0, pclk_b = 1'b0, ppen_b = 1'b0;

  always @(posedge clk) begin
    #1;
    if (s_clk_a && !pclk_a) begin model_a = {model_a[62:0], s_out_a}; rises_a++; end
    if (s_pen_a && !ppen_a) begin latched_a = model_a; pens_a++; end
    if (done_a) dones_a++;
    if (s_clk_a && !busy_a) viol_a++;
    pclk_a = s_clk_a; ppen_a = s_pen_a;
    if (s_clk_b && !pclk_b) begin model_b = {model_b[62:0], s_out_b}; rises_b++; end
    if (s_pen_b && !ppen_b) begin latched_b = model_b; pens_b++; end
    if (done_b) dones_b++;
    if (s_clk_b && !busy_b) viol_b++;
    pclk_b = s_clk_b; ppen_b = s_pen_b;
  end

  logic tr_busy [0:600];
  logic tr_done [0:600];
  logic tr_out  [0:600];
  logic tr_pen  [0:600];
  logic tr_clk  [0:600];

  task automatic launch_a(input logic [63:0] d);
    @(negedge clk); start_a = 1'b1; par_a = d;
    @(posedge clk);
  endtask

  // Records cycles 1..n after the accepting edge; par_data is scrambled once busy.
  task automatic rec(input bit sel_b, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (sel_b) begin start_b = 1'b0; par_b = ~par_b; end
        else begin start_a = 1'b0; par_a = ~par_a; end
      end
      tr_busy[k] = sel_b ? busy_b  : busy_a;
      tr_done[k] = sel_b ? done_b  : done_a;
      tr_out[k]  = sel_b ? s_out_b : s_out_a;
      tr_pen[k]  = sel_b ? s_pen_b : s_pen_a;
      tr_clk[k]  = sel_b ? s_clk_b : s_clk_a;
    end
  endtask

  task automatic analyze(input int n, output int blen, output int first_low,
                         output int dcnt, output int dat);
    blen = 0; first_low = 0; dcnt = 0; dat = 0;
    for (int k = 1; k <= n; k++) begin
      if (tr_busy[k]) blen++;
      else if (first_low == 0) first_low = k;
      if (tr_done[k]) begin dcnt++; dat = k; end
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [63:0] exp_latch;
  } vec_t;

  vec_t vecs [5];

  task automatic frame_a(input string tag, input logic [63:0] d, input logic [63:0] exp);
    int r0, p0, blen, fl, dcnt, dat;
    r0 = rises_a; p0 = pens_a;
    launch_a(d);
    rec(1'b0, 262);
    analyze(262, blen, fl, dcnt, dat);
    check({tag, " busy_len"}, 64'(blen), 64'd258);
    check({tag, " busy_end"}, 64'(fl), 64'd259);
    check({tag, " done_cnt"}, 64'(dcnt), 64'd1);
    check({tag, " done_at"}, 64'(dat), 64'd259);
    check({tag, " rises"}, 64'(rises_a - r0), 64'd64);
    check({tag, " pens"}, 64'(pens_a - p0), 64'd1);
    check({tag, " latched"}, latched_a, exp);
  endtask

  initial begin
    int mism, nb, p0, d0, blen, fl, dcnt, dat;
    logic [63:0] lat1;

    vecs[0] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({busy_a, done_a, s_clk_a, s_out_a, s_pen_a, s_clrn_a}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("clrn_after_reset", 64'(s_clrn_a), 64'd1);

    for (int i = 0; i < 5; i++) begin
      frame_a($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_latch);
      if (i == 0) begin
        mism = 0;
        for (int k = 1; k <= 262; k++) begin
          if (tr_out[k] !== ((k <= 4) || (k >= 253 && k <= 256))) mism++;
          if (tr_pen[k] !== (k == 257 || k == 258)) mism++;
        end
        check("vec0 sout_pen_pattern", 64'(mism), 64'd0);
      end
    end

    // Back-to-back frames with start held in the DONE cycle.
    p0 = pens_a; d0 = dones_a; nb = 0; lat1 = '0;
    launch_a(64'hAAAA_AAAA_AAAA_AAAA);
    for (int k = 1; k <= 520; k++) begin
      @(negedge clk);
      if (k == 1) start_a = 1'b0;
      tr_busy[k] = busy_a; tr_done[k] = done_a;
      if (k <= 517 && !busy_a) nb++;
      if (k == 259) begin
        check("b2b done_in_gap", 64'(done_a), 64'd1);
        lat1 = latched_a; start_a = 1'b1; par_a = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      if (k == 260) begin start_a = 1'b0; par_a = '0; end
    end
    check("b2b frame1", lat1, 64'hAAAA_AAAA_AAAA_AAAA);
    check("b2b frame2", latched_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b idle_cycles", 64'(nb), 64'd1);
    check("b2b done2_at_518", 64'(tr_done[518]), 64'd1);
    check("b2b pens", 64'(pens_a - p0), 64'd2);
    check("b2b dones", 64'(dones_a - d0), 64'd2);

    // start while busy is ignored.
    p0 = pens_a; d0 = dones_a;
    launch_a(64'h0F1E_2D3C_4B5A_6978);
    for (int k = 1; k <= 262; k++) begin
      @(negedge clk);
      if (k == 1) start_a = 1'b0;
      if (k == 50) begin start_a = 1'b1; par_a = 64'hDEAD_BEEF_CAFE_F00D; end
      if (k == 51) start_a = 1'b0;
      tr_busy[k] = busy_a; tr_done[k] = done_a;
    end
    analyze(262, blen, fl, dcnt, dat);
    check("ign latched", latched_a, 64'h0F1E_2D3C_4B5A_6978);
    check("ign busy_len", 64'(blen), 64'd258);
    check("ign dones", 64'(dones_a - d0), 64'd1);
    check("ign pens", 64'(pens_a - p0), 64'd1);

    // Reset mid-frame.
    p0 = pens_a; d0 = dones_a;
    launch_a(64'h1122_3344_5566_7788);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) start_a = 1'b0;
      if (k == 100) rst = 1'b1;
      if (k == 101) begin
        check("midrst outputs", 64'({busy_a, done_a, s_clk_a, s_out_a, s_pen_a, s_clrn_a}), 64'd0);
        rst = 1'b0;
      end
      if (k == 102) check("midrst clrn_back", 64'({s_clrn_a, busy_a}), 64'b10);
    end
    check("midrst no_pen", 64'(pens_a - p0), 64'd0);
    check("midrst no_done", 64'(dones_a - d0), 64'd0);
    frame_a("after_rst", 64'hC3C3_5A5A_0FF0_9669, 64'hC3C3_5A5A_0FF0_9669);

    // Reset held with start high: frame begins on first edge with rst low.
    @(negedge clk); rst = 1'b1; start_a = 1'b1; par_a = 64'h7E57_0000_FFFF_1234;
    nb = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy_a) nb++;
    end
    check("rsthold no_busy", 64'(nb), 64'd0);
    rst = 1'b0;
    p0 = pens_a;
    @(posedge clk);
    rec(1'b0, 262);
    analyze(262, blen, fl, dcnt, dat);
    check("rsthold busy_at_1", 64'(tr_busy[1]), 64'd1);
    check("rsthold done_at", 64'(dat), 64'd259);
    check("rsthold latched", latched_a, 64'h7E57_0000_FFFF_1234);
    check("rsthold pens", 64'(pens_a - p0), 64'd1);

    // CLK_DIV = 1 instance.
    p0 = rises_b;
    @(negedge clk); start_b = 1'b1; par_b = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    rec(1'b1, 134);
    analyze(134, blen, fl, dcnt, dat);
    mism = 0;
    for (int k = 1; k <= 128; k++) if (tr_clk[k] !== (k % 2 == 0)) mism++;
    check("div1 clk_toggle", 64'(mism), 64'd0);
    check("div1 busy_len", 64'(blen), 64'd129);
    check("div1 busy_end", 64'(fl), 64'd130);
    check("div1 done_at", 64'(dat), 64'd130);
    check("div1 done_cnt", 64'(dcnt), 64'd1);
    check("div1 rises", 64'(rises_b - p0), 64'd64);
    check("div1 latched", latched_b, 64'h0123_4567_89AB_CDEF);

    check("sclk_outside_busy", 64'(viol_a + viol_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
